// File: rtl/commu_slot.sv
// TDMA slot scheduler: counts slots per frame, opens this node's slot and supervises the burst.
// Optional build macro COMMU_SLOT_SHORT_EN forces a 100-cycle slot and 10-cycle guard for fast simulation.
module commu_slot #(
  parameter logic [31:0] SLOT_LEN = 32'd50_000,
  parameter logic [31:0] GUARD    = 32'd1_000,
  parameter logic [3:0]  NUM_SLOT = 4'd8
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       slot_begin,
  input  logic       slot_en,
  input  logic [3:0] node_id,
  input  logic       done_tail,
  output logic       slot_rdy,
  output logic [3:0] slot_idx,
  output logic       in_frame,
  output logic       slot_miss,
  output logic       frame_done
);

`ifdef COMMU_SLOT_SHORT_EN
  localparam logic [31:0] EFF_LEN   = 32'd100;
  localparam logic [31:0] EFF_GUARD = 32'd10;
`else
  localparam logic [31:0] EFF_LEN   = SLOT_LEN;
  localparam logic [31:0] EFF_GUARD = GUARD;
`endif

  localparam logic [31:0] LEN_M1   = EFF_LEN - 32'd1;
  localparam logic [31:0] GUARD_M1 = EFF_GUARD - 32'd1;
  localparam logic [3:0]  LAST_IDX = NUM_SLOT - 4'd1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_RDY, S_TX} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [3:0]  r_idx;
  logic [3:0]  r_id_q;
  logic        w_start;
  logic        w_slot_end;
  logic        w_frame_end;
  logic        w_miss;

  assign w_start     = slot_begin & slot_en;
  assign w_slot_end  = (r_cnt == LEN_M1);
  assign w_frame_end = (r_state != S_IDLE) & w_slot_end & (r_idx == LAST_IDX);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_miss      = 1'b0;
    if (w_start) begin
      // A frame-start pulse always restarts; an open or active burst is reported as missed.
      w_state_nxt = S_COUNT;
      w_miss      = (r_state == S_RDY) || (r_state == S_TX);
    end else begin
      case (r_state)
        S_COUNT: begin
          if ((r_idx == r_id_q) && (r_cnt == GUARD_M1)) w_state_nxt = S_RDY;
          else if (w_frame_end)                         w_state_nxt = S_IDLE;
        end
        S_RDY: w_state_nxt = S_TX;
        S_TX: begin
          if (w_frame_end) begin
            w_state_nxt = S_IDLE;
            w_miss      = ~done_tail;
          end else if (done_tail) begin
            w_state_nxt = S_COUNT;
          end else if (w_slot_end) begin
            w_state_nxt = S_COUNT;
            w_miss      = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_id_q  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt  <= '0;
        r_idx  <= '0;
        r_id_q <= node_id;
      end else if (r_state != S_IDLE) begin
        if (w_frame_end) begin
          r_cnt <= '0;
          r_idx <= '0;
        end else if (w_slot_end) begin
          r_cnt <= '0;
          r_idx <= r_idx + 4'd1;
        end else begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
    end
  end

  assign slot_rdy   = (r_state == S_RDY);
  assign in_frame   = (r_state != S_IDLE);
  assign slot_idx   = r_idx;
  assign slot_miss  = w_miss;
  assign frame_done = w_frame_end;

endmodule
